// File: rtl/shift_control_8.sv
// shift_control_8: turns load/execute requests into the per-cycle load and
// shift strobes for the 8-bit shift registers. One execute request produces
// SHIFT_COUNT consecutive shift cycles followed by a single Done pulse. The
// request must then be released before another sequence can start.
//
// state | meaning
// IDLE  | waiting for Execute; load requests pass straight through
// SHIFT | Shift_En high, counter stepping 0..SHIFT_COUNT-1
// HOLD  | sequence finished, waiting for Execute to be released
module shift_control_8 #(
    parameter int SHIFT_COUNT = 8,
    parameter int CNT_W       = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Execute,
    input  logic             LoadA_In,
    input  logic             LoadB_In,
    output logic             LoadA,
    output logic             LoadB,
    output logic             Shift_En,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Shift_Count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_COUNT - 1);

    state_t state;

    // Sequencer: state, counter and the registered Shift_En/Busy/Done outputs.
    // Shift_En and Busy are set on the same edges that enter/leave the states
    // they decode, so they always equal a decode of the state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            Shift_Count <= '0;
            Shift_En    <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Execute) begin
                        state       <= SHIFT;
                        Shift_Count <= '0;
                        Shift_En    <= 1'b1;
                        Busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (Shift_Count == LAST_CNT) begin
                        state       <= HOLD;
                        Shift_Count <= '0;
                        Shift_En    <= 1'b0;
                        Done        <= 1'b1;
                    end else begin
                        Shift_Count <= Shift_Count + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!Execute) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    Shift_Count <= '0;
                    Shift_En    <= 1'b0;
                    Busy        <= 1'b0;
                end
            endcase
        end
    end

    // Load strobes are zero-latency; Execute takes priority over a load.
    always_comb begin
        LoadA = (state == IDLE) && LoadA_In && !Execute;
        LoadB = (state == IDLE) && LoadB_In && !Execute;
    end

endmodule

// File: tb/tb_shift_control_8.sv
// Bench for shift_control_8: two instances (SHIFT_COUNT=8 and =1) share the
// same stimulus and are compared every cycle against a sequence-level model.
module tb_shift_control_8;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Execute = 1'b0;
    logic LoadA_In = 1'b0;
    logic LoadB_In = 1'b0;

    logic la8, lb8, se8, busy8, done8;
    logic [3:0] cnt8;
    logic la1, lb1, se1, busy1, done1;
    logic [0:0] cnt1;

    int n_compared = 0;
    int n_mismatched = 0;

    // model: shift index in progress (-1 when not shifting), waiting-release flag, done pulse
    int m_k[2];
    bit m_hold[2];
    bit m_done[2];
    int m_sc[2];

    int se_seen[2];
    int done_seen[2];

    always #5 Clk = ~Clk;

    shift_control_8 #(.SHIFT_COUNT(8), .CNT_W(4)) dut8 (
        .Clk(Clk), .Reset(Reset), .Execute(Execute),
        .LoadA_In(LoadA_In), .LoadB_In(LoadB_In),
        .LoadA(la8), .LoadB(lb8), .Shift_En(se8), .Busy(busy8),
        .Done(done8), .Shift_Count(cnt8)
    );

    shift_control_8 #(.SHIFT_COUNT(1), .CNT_W(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Execute(Execute),
        .LoadA_In(LoadA_In), .LoadB_In(LoadB_In),
        .LoadA(la1), .LoadB(lb1), .Shift_En(se1), .Busy(busy1),
        .Done(done1), .Shift_Count(cnt1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_k[i] = -1;
            m_hold[i] = 1'b0;
            m_done[i] = 1'b0;
        end
    endtask

    // One rising edge of the sequence-level model, using inputs sampled at the edge.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                m_k[i] = -1;
                m_hold[i] = 1'b0;
                m_done[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                if (m_k[i] >= 0) begin
                    if (m_k[i] == m_sc[i] - 1) begin
                        m_k[i] = -1;
                        m_hold[i] = 1'b1;
                        m_done[i] = 1'b1;
                    end else begin
                        m_k[i] = m_k[i] + 1;
                    end
                end else if (m_hold[i]) begin
                    if (!Execute) m_hold[i] = 1'b0;
                end else if (Execute) begin
                    m_k[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        int exp_se[2], exp_busy[2], exp_cnt[2], exp_la[2], exp_lb[2];
        for (int i = 0; i < 2; i++) begin
            bit idle;
            idle = (m_k[i] < 0) && !m_hold[i];
            exp_se[i] = (m_k[i] >= 0) ? 1 : 0;
            exp_busy[i] = idle ? 0 : 1;
            exp_cnt[i] = (m_k[i] >= 0) ? m_k[i] : 0;
            exp_la[i] = (idle && LoadA_In && !Execute) ? 1 : 0;
            exp_lb[i] = (idle && LoadB_In && !Execute) ? 1 : 0;
        end
        check({ph, "_se8"}, int'(se8), exp_se[0]);
        check({ph, "_busy8"}, int'(busy8), exp_busy[0]);
        check({ph, "_done8"}, int'(done8), int'(m_done[0]));
        check({ph, "_cnt8"}, int'(cnt8), exp_cnt[0]);
        check({ph, "_loada8"}, int'(la8), exp_la[0]);
        check({ph, "_loadb8"}, int'(lb8), exp_lb[0]);
        check({ph, "_se1"}, int'(se1), exp_se[1]);
        check({ph, "_busy1"}, int'(busy1), exp_busy[1]);
        check({ph, "_done1"}, int'(done1), int'(m_done[1]));
        check({ph, "_cnt1"}, int'(cnt1), exp_cnt[1]);
        check({ph, "_loada1"}, int'(la1), exp_la[1]);
        check({ph, "_loadb1"}, int'(lb1), exp_lb[1]);
    endtask

    // Advance one clock, check, then drive the inputs for the next edge and recheck loads.
    task automatic cycle(input logic ex, input logic la, input logic lb);
        @(posedge Clk);
        model_edge();
        #2;
        check_all("edge");
        se_seen[0] += int'(se8);
        se_seen[1] += int'(se1);
        done_seen[0] += int'(done8);
        done_seen[1] += int'(done1);
        Execute = ex;
        LoadA_In = la;
        LoadB_In = lb;
        #1;
        check_all("drive");
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 2; i++) begin
            se_seen[i] = 0;
            done_seen[i] = 0;
        end
    endtask

    // Asynchronous reset asserted mid-cycle, held for some edges, released mid-cycle.
    task automatic pulse_reset(input int hold_cycles);
        Reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (hold_cycles) cycle(Execute, LoadA_In, LoadB_In);
        Reset = 1'b0;
        #1;
        check_all("rst_release");
    endtask

    initial begin
        logic ex;
        m_sc[0] = 8;
        m_sc[1] = 1;
        model_reset();
        clear_seen();

        // reset held from time zero
        #1;
        check_all("por");
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // single execute held for 3 cycles
        clear_seen();
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (14) cycle(1'b0, 1'b0, 1'b0);
        check("single_shifts8", se_seen[0], 8);
        check("single_done8", done_seen[0], 1);
        check("single_shifts1", se_seen[1], 1);
        check("single_done1", done_seen[1], 1);

        // execute held for 20 cycles: one sequence only
        clear_seen();
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        check("held_busy8", int'(busy8), 1);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        check("held_shifts8", se_seen[0], 8);
        check("held_done8", done_seen[0], 1);
        check("held_idle8", int'(busy8), 0);

        // load arbitration
        cycle(1'b0, 1'b1, 1'b0);
        check("loada_idle", int'(la8), 1);
        cycle(1'b1, 1'b1, 1'b0);
        check("loada_exec_wins", int'(la8), 0);
        repeat (10) cycle(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // reset after 4 shifts, then a fresh full sequence
        clear_seen();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        check("mid_shifts8", se_seen[0], 4);
        #2;
        pulse_reset(2);
        check("mid_no_done8", done_seen[0], 0);
        Execute = 1'b1;
        clear_seen();
        cycle(1'b0, 1'b0, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);
        check("fresh_shifts8", se_seen[0], 8);
        check("fresh_done8", done_seen[0], 1);

        // randomized traffic with occasional async resets
        ex = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) ex = ~ex;
            cycle(ex, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 199) == 0) begin
                #($urandom_range(1, 4));
                pulse_reset($urandom_range(0, 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
